// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - sequential instruction prefetch queue between ROM and decode
//
// Issues sequential byte fetches from an 8-bit PC, buffers each returned byte
// with its PC in a DEPTH-entry FIFO, and presents the head to decode under a
// valid/ready handshake. A branch redirect flushes the queue, kills any
// in-flight response and restarts fetch at the target in the same cycle.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   imem_req/imem_addr  fetch request and address (combinational)
//   imem_rdata          ROM byte, valid the cycle after the request
//   redirect_valid/_pc  branch redirect from EX and its target
//   instr_valid/_code/_pc/_ready  head of queue handshake to decode
//   occupancy           number of entries held
//   perf_fetches/perf_flushes  request / redirect counters (PFQ_PERF_EN only)
//
// Optional feature macro: PFQ_PERF_EN
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [7:0]               imem_addr,
  input  logic [7:0]               imem_rdata,
  input  logic                     redirect_valid,
  input  logic [7:0]               redirect_pc,
  output logic                     instr_valid,
  output logic [7:0]               instr_code,
  output logic [7:0]               instr_pc,
  input  logic                     instr_ready,
`ifdef PFQ_PERF_EN
  output logic [15:0]              perf_fetches,
  output logic [7:0]               perf_flushes,
`endif
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          inflight_q, inflight_d;
  logic [7:0]    inflight_pc_q, inflight_pc_d;
  logic [7:0]    fetch_pc_q, fetch_pc_d;
  logic [7:0]    mem_code_q [DEPTH];
  logic [7:0]    mem_pc_q   [DEPTH];

  logic credit_ok;
  logic push;
  logic pop;

  // Credit counts the in-flight response as already occupying a slot, so the
  // queue can never overflow. A pop this cycle deliberately grants no credit.
  assign credit_ok   = (int'(count_q) + int'(inflight_q)) < DEPTH;
  assign imem_req    = reset & (redirect_valid | credit_ok);
  assign imem_addr   = redirect_valid ? redirect_pc : fetch_pc_q;

  assign instr_valid = (count_q != '0);
  assign instr_code  = instr_valid ? mem_code_q[rd_ptr_q] : 8'h00;
  assign instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q]   : 8'h00;
  assign occupancy   = count_q;

  // A redirect discards the response arriving this cycle and ignores any pop.
  assign push = inflight_q & ~redirect_valid;
  assign pop  = instr_valid & instr_ready & ~redirect_valid;

  always_comb begin
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    inflight_d    = imem_req;
    inflight_pc_d = imem_addr;
    fetch_pc_d    = fetch_pc_q;

    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (imem_req) fetch_pc_d = imem_addr + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 8'h00;
      fetch_pc_q    <= RESET_PC;
    end else begin
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_code_q[wr_ptr_q] <= imem_rdata;
      mem_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

`ifdef PFQ_PERF_EN
  logic [15:0] perf_fetches_q, perf_fetches_d;
  logic [7:0]  perf_flushes_q, perf_flushes_d;

  always_comb begin
    perf_fetches_d = perf_fetches_q + 16'(imem_req);
    perf_flushes_d = perf_flushes_q;
    if (redirect_valid && perf_flushes_q != 8'hFF) perf_flushes_d = perf_flushes_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetches_q <= 16'h0000;
      perf_flushes_q <= 8'h00;
    end else begin
      perf_fetches_q <= perf_fetches_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_fetches = perf_fetches_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule
